// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The helper decides whether a byte address lands inside instruction memory.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    END   = 2'd2
  } state_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic wordInRange(input logic [31:0] addr, input int unsigned words);
    return (addr >> 2) < words;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Single-stage instruction fetch: pc register, one-entry output register and a
// START/FETCH/END controller, with branch redirect and decode back-pressure.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        done
);

  localparam logic [31:0] AlignMask = ~(WORD_BYTES - 32'd1);

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_pc;
  logic [31:0] r_ifInstr;
  logic [31:0] r_ifPc;
  logic        r_ifValid;
  logic        w_done;
  logic [31:0] w_branchTarget;
  logic        w_pcInRange;
  logic        w_branchInRange;
  logic        w_transfer;
  logic        w_load;

  assign w_branchTarget  = branch_addr & AlignMask;
  assign w_pcInRange     = wordInRange(r_pc, MEM_WORDS);
  assign w_branchInRange = wordInRange(w_branchTarget, MEM_WORDS);
  assign w_transfer      = r_ifValid & id_ready;
  // A branch always wins, so loading is only considered when no redirect is present.
  assign w_load = !branch_taken && (r_state == FETCH) && w_pcInRange &&
                  (!r_ifValid || id_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= START;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (branch_taken) begin
      w_nextState = w_branchInRange ? FETCH : END;
    end else begin
      case (r_state)
        START:   w_nextState = FETCH;
        FETCH:   w_nextState = w_pcInRange ? FETCH : END;
        END:     w_nextState = END;
        default: w_nextState = START;
      endcase
    end
  end

  always_comb begin
    w_done = (r_state == END) && !r_ifValid;
  end

  // Out of range or in END, the held instruction still drains to decode once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC & AlignMask;
      r_ifValid <= 1'b0;
      r_ifInstr <= 32'h0;
      r_ifPc    <= 32'h0;
    end else if (branch_taken) begin
      r_pc      <= w_branchTarget;
      r_ifValid <= 1'b0;
    end else if (w_load) begin
      r_ifInstr <= instruction;
      r_ifPc    <= r_pc;
      r_ifValid <= 1'b1;
      r_pc      <= r_pc + WORD_BYTES;
    end else if (w_transfer) begin
      r_ifValid <= 1'b0;
    end
  end

  assign pc       = r_pc;
  assign if_valid = r_ifValid;
  assign if_instr = r_ifInstr;
  assign if_pc    = r_ifPc;
  assign done     = w_done;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit against a transaction-level program model.
module tb_fetch_unit;

  localparam int MemWords = 7;
  localparam int PhaseStart = 0;
  localparam int PhaseFetch = 1;
  localparam int PhaseEnd = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        done;

  logic [31:0] instructionMemory [MemWords];

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        done;
  } snap_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } xfer_t;

  snap_t snapQ[$];
  xfer_t xferQ[$];
  snap_t monSnap;
  xfer_t monXfer;

  int checks = 0;
  int passes = 0;
  int transfersSeen = 0;

  int          mPhase;
  logic [31:0] mPc;
  logic [31:0] mIfPc;
  logic [31:0] mIfInstr;
  logic        mValid;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .MEM_WORDS(MemWords)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .instruction (instruction),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .id_ready    (id_ready),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .done        (done)
  );

  always #5 clk = ~clk;

  assign instruction = ((pc >> 2) < 32'(MemWords)) ? instructionMemory[pc[4:2]] : 32'hDEAD_BEEF;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic modelInRange(input logic [31:0] addr);
    return (addr / 4) < 32'(MemWords);
  endfunction

  task automatic modelReset();
    mPhase   = PhaseStart;
    mPc      = 32'h0;
    mValid   = 1'b0;
    mIfPc    = 32'h0;
    mIfInstr = 32'h0;
  endtask

  // One cycle of the program-level behaviour: redirect, start-up, fetch, or drain.
  task automatic modelStep(input logic ready, input logic br, input logic [31:0] addr);
    if (br) begin
      mPc    = addr - (addr % 4);
      mValid = 1'b0;
      mPhase = modelInRange(mPc) ? PhaseFetch : PhaseEnd;
    end else if (mPhase == PhaseStart) begin
      mPhase = PhaseFetch;
    end else if (mPhase == PhaseFetch && modelInRange(mPc)) begin
      if (!mValid || ready) begin
        mIfPc    = mPc;
        mIfInstr = instructionMemory[mPc / 4];
        mValid   = 1'b1;
        mPc      = mPc + 32'd4;
      end
    end else begin
      mPhase = PhaseEnd;
      if (mValid && ready) mValid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic br, input logic [31:0] addr);
    snap_t s;
    xfer_t x;
    id_ready     = ready;
    branch_taken = br;
    branch_addr  = addr;
    s.valid = mValid;
    s.pc    = mPc;
    s.done  = (mPhase == PhaseEnd) && !mValid;
    snapQ.push_back(s);
    if (mValid && ready) begin
      x.pc    = mIfPc;
      x.instr = mIfInstr;
      xferQ.push_back(x);
    end
    modelStep(ready, br, addr);
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("reset pc", pc, 32'h0);
    checkOutput("reset if_valid", if_valid, 0);
    checkOutput("reset if_pc", if_pc, 32'h0);
    checkOutput("reset if_instr", if_instr, 32'h0);
    checkOutput("reset done", done, 0);
    id_ready     = 1'b0;
    branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    snapQ.delete();
    xferQ.delete();
    modelReset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic runUntilIfPc(input logic [31:0] target);
    int n = 0;
    while (!(mValid && mIfPc == target) && n < 50) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      n++;
    end
    if (n == 50) begin
      checks++;
      $display("[TB] FAIL reach if_pc %h: timed out, expected within 50 cycles", target);
    end else begin
      checkOutput("reached if_pc", if_pc, target);
    end
  endtask

  // Monitor: compares every observed cycle and every observed transfer against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && snapQ.size() > 0) begin
        monSnap = snapQ.pop_front();
        checkOutput("if_valid", if_valid, monSnap.valid);
        checkOutput("pc", pc, monSnap.pc);
        checkOutput("done", done, monSnap.done);
        if (if_valid && id_ready) begin
          transfersSeen++;
          if (xferQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL transfer: got if_pc %h, expected no transfer", if_pc);
          end else begin
            monXfer = xferQ.pop_front();
            checkOutput("xfer if_pc", if_pc, monXfer.pc);
            checkOutput("xfer if_instr", if_instr, monXfer.instr);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic rr;
    logic rb;
    logic [31:0] ra;
    for (int i = 0; i < MemWords; i++) instructionMemory[i] = $urandom;
    modelReset();
    #2;
    doReset();

    transfersSeen = 0;
    repeat (12) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("straight-run transfers", transfersSeen, 7);
    checkOutput("straight-run done", done, 1);

    doReset();
    runUntilIfPc(32'h8);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("stall if_pc", if_pc, 32'h8);
    checkOutput("stall pc", pc, 32'hC);
    checkOutput("stall if_instr", if_instr, instructionMemory[2]);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("after stall if_pc", if_pc, 32'hC);

    doReset();
    runUntilIfPc(32'h4);
    applyStimulus(1'b1, 1'b1, 32'h0000_0011);
    checkOutput("branch squash", if_valid, 0);
    checkOutput("branch pc", pc, 32'h10);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("branch target if_pc", if_pc, 32'h10);

    applyStimulus(1'b1, 1'b1, 32'h40);
    checkOutput("oor branch if_valid", if_valid, 0);
    checkOutput("oor branch done", done, 1);
    repeat (2) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("restart if_pc", if_pc, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h14);
    checkOutput("branch beats stall", if_valid, 0);
    checkOutput("branch beats stall pc", pc, 32'h14);

    doReset();
    applyStimulus(1'b1, 1'b1, 32'h8);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("start branch if_pc", if_pc, 32'h8);

    doReset();
    runUntilIfPc(32'hC);
    doReset();
    repeat (4) applyStimulus(1'b1, 1'b0, 32'h0);

    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) doReset();
      rr = ($urandom_range(0, 3) != 0);
      rb = ($urandom_range(0, 9) == 0);
      ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      applyStimulus(rr, rb, ra);
    end

    checkOutput("leftover transfers", 32'(xferQ.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
